dynamic_branch_predictor: RTL and testbench
===========================================

// Module: dynamic_branch_predictor
// PURPOSE
// Fetch-stage predictor that replaces static backward-taken/forward-not-taken branch prediction.
// - Conditional branches: a PC-indexed table (BHT) of saturating counters, trained from execute.
// - JALR returns: a return-address stack (RAS); JAL remains always-taken.
// - Prediction outputs are combinational from RD/PC_f, so fetch timing is unchanged.
// - Training and RAS updates are sequential.
// PARAMETERS
// DATA_WIDTH      32  instruction/PC width
// BHT_INDEX_BITS  6   BHT has 2**BHT_INDEX_BITS entries, index = PC[BHT_INDEX_BITS+1:2]
// CTR_BITS        2   counter width (>=1); predict taken when counter MSB = 1
// RAS_DEPTH       4   RAS entries, power of two, >=2
// PORTS
// clk            in   1           clock, all state on rising edge
// rst            in   1           asynchronous active-high reset
// fetch_en       in   1           fetch stage advancing this cycle (RAS may push/pop)
// RD             in   DATA_WIDTH  instruction word in fetch
// PC_f           in   DATA_WIDTH  PC of RD
// update_en      in   1           execute resolved a conditional branch this cycle
// update_pc      in   DATA_WIDTH  PC of resolved branch
// update_taken   in   1           actual outcome
// branch_target  out  DATA_WIDTH  predicted next PC when predict_taken=1, else PC_f+4
// predict_taken  out  1           1 = redirect fetch to branch_target
// BEHAVIOUR
// Reset (async, any time, including mid-operation):
// - All BHT counters = 2**(CTR_BITS-1)-1 (weakly not-taken).
// - RAS empty: count=0, top pointer=0.
// - Outputs are combinational; after reset every branch predicts not-taken.
// Decode (opcode RD[6:0]; rd=RD[11:7]; rs1=RD[19:15]; link reg = x1 or x5):
// - 1100011 branch:
//   - target = PC_f + sext B-imm.
//   - predict_taken = MSB of BHT[PC_f index].
// - 1101111 JAL: target = PC_f + sext J-imm; predict_taken=1.
// - 1100111 JALR:
//   - If rs1 is link and RAS non-empty: target = RAS top (value before any pop this cycle); predict_taken=1.
//   - Otherwise: target = PC_f+4; predict_taken=0.
// - Other opcodes: target = PC_f+4; predict_taken=0.
// - All adds are DATA_WIDTH-bit and wrap modulo 2**DATA_WIDTH.
// BHT update (clock edge where update_en=1):
// - Entry = update_pc index.
// - taken: counter+1, saturating at 2**CTR_BITS-1.
// - not-taken: counter-1, saturating at 0.
// - Same-cycle fetch read of the index being updated returns the OLD value; the new value is visible next cycle (no bypass).
// - Aliasing between PCs sharing an index is permitted.
// RAS actions (only when fetch_en=1; no action when fetch_en=0):
// - JAL/JALR with rd link, rs1 not link: push PC_f+4.
// - JALR with rd not link, rs1 link: pop.
// - JALR, rd and rs1 both link, rd!=rs1: pop then push PC_f+4 (net: top replaced, count unchanged).
// - JALR, rd==rs1 link: push only.
// - Push when full: overwrite oldest entry; count stays RAS_DEPTH; pointer wraps modulo RAS_DEPTH.
// - Pop when empty: no state change.
// - Wrong-path pushes/pops are not repaired; this costs accuracy only, never correctness.
// - BHT update and RAS action in the same cycle are independent.
// TESTING
// 1 Reset, then branch at PC 0x100 with offset -8.
//   -> predict_taken=0, target=0xF8 (counter 01).
// 2 Two update_en taken at PC 0x100, then fetch it.
//   -> predict_taken=1, target=0xF8.
//   -> Three further taken updates: counter holds at 11.
//   -> Then two not-taken updates: predict 0.
// 3 Fetch JAL x1 at 0x200 (fetch_en=1), then JALR x0,0(x1) at 0x400.
//   -> JAL: predict 1, target = 0x200 + imm.
//   -> JALR: predict 1, target=0x204; RAS empty afterwards.
// 4 Push 5 return addresses A0..A4 with RAS_DEPTH=4, then 5 pops.
//   -> Pops return A4,A3,A2,A1.
//   -> 5th pop: predict 0, target=PC_f+4.
// 5 update_en for index i in the same cycle as a fetch of the same index.
//   -> Prediction uses the old counter; next cycle uses the new one.
//   -> JALR with fetch_en=0: RAS count unchanged.
// 6 Assert rst mid-sequence with RAS non-empty and counters trained.
//   -> Outputs immediately reflect reset state: branch not-taken, JALR x0,0(x1) predicts 0.

Source files
------------

// File: rtl/dynamic_branch_predictor_if.sv
// Fetch/execute bundle for the dynamic branch predictor.
// Fetch and training inputs, plus the combinational prediction.
interface dynamic_branch_predictor_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fetch_en;
  logic [DATA_WIDTH-1:0] RD;
  logic [DATA_WIDTH-1:0] PC_f;
  logic                  update_en;
  logic [DATA_WIDTH-1:0] update_pc;
  logic                  update_taken;
  logic [DATA_WIDTH-1:0] branch_target;
  logic                  predict_taken;

  modport master (
    output fetch_en,
    output RD,
    output PC_f,
    output update_en,
    output update_pc,
    output update_taken,
    input  branch_target,
    input  predict_taken
  );

  modport slave (
    input  fetch_en,
    input  RD,
    input  PC_f,
    input  update_en,
    input  update_pc,
    input  update_taken,
    output branch_target,
    output predict_taken
  );
endinterface

// File: rtl/dynamic_branch_predictor.sv
// Fetch-stage predictor: saturating-counter BHT for branches,
// return-address stack for JALR returns, always-taken JAL.
module dynamic_branch_predictor #(
  parameter int DATA_WIDTH     = 32,
  parameter int BHT_INDEX_BITS = 6,
  parameter int CTR_BITS       = 2,
  parameter int RAS_DEPTH      = 4
) (
  input logic clk,
  input logic rst,
  dynamic_branch_predictor_if.slave bp
);
  localparam int BHT_N = 1 << BHT_INDEX_BITS;
  localparam int PW    = $clog2(RAS_DEPTH);
  localparam int CW    = PW + 1;

  localparam logic [CTR_BITS-1:0] CTR_INIT =
    CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CW-1:0]       FULL     = CW'(RAS_DEPTH);

  logic [CTR_BITS-1:0]   bht [BHT_N];
  logic [DATA_WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]         ptr;
  logic [CW-1:0]         count;

  logic [6:0] opc;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       is_br;
  logic       is_jal;
  logic       is_jalr;
  logic       rd_link;
  logic       rs1_link;

  logic [BHT_INDEX_BITS-1:0] f_idx;
  logic [BHT_INDEX_BITS-1:0] u_idx;
  logic [CTR_BITS-1:0]       u_ctr;

  logic [PW-1:0]         top_idx;
  logic [DATA_WIDTH-1:0] ras_top;
  logic                  ras_nz;
  logic [DATA_WIDTH-1:0] pc4;
  logic [DATA_WIDTH-1:0] b_imm;
  logic [DATA_WIDTH-1:0] j_imm;
  logic                  do_push;
  logic                  do_pop;

  assign opc      = bp.RD[6:0];
  assign rd       = bp.RD[11:7];
  assign rs1      = bp.RD[19:15];
  assign is_br    = opc == 7'b1100011;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);

  assign f_idx = bp.PC_f[BHT_INDEX_BITS+1:2];
  assign u_idx = bp.update_pc[BHT_INDEX_BITS+1:2];
  assign u_ctr = bht[u_idx];

  // ptr is the next free slot; the top lives one below it
  assign top_idx = ptr - 1'b1;
  assign ras_top = ras[top_idx];
  assign ras_nz  = count != '0;
  assign pc4     = bp.PC_f + DATA_WIDTH'(4);

  assign b_imm = {{(DATA_WIDTH-12){bp.RD[31]}},
                  bp.RD[7], bp.RD[30:25],
                  bp.RD[11:8], 1'b0};
  assign j_imm = {{(DATA_WIDTH-20){bp.RD[31]}},
                  bp.RD[19:12], bp.RD[20],
                  bp.RD[30:21], 1'b0};

  always_comb begin
    bp.predict_taken = 1'b0;
    bp.branch_target = pc4;
    unique case (1'b1)
      is_br: begin
        bp.branch_target = bp.PC_f + b_imm;
        bp.predict_taken = bht[f_idx][CTR_BITS-1];
      end
      is_jal: begin
        bp.branch_target = bp.PC_f + j_imm;
        bp.predict_taken = 1'b1;
      end
      is_jalr: begin
        if (rs1_link && ras_nz) begin
          bp.branch_target = ras_top;
          bp.predict_taken = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // rd==rs1 link means a plain call, not a coroutine swap
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (bp.fetch_en) begin
      if (is_jal) do_push = rd_link;
      if (is_jalr) begin
        do_push = rd_link;
        do_pop  = rs1_link &&
                  (!rd_link || rd != rs1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++)
        bht[i] <= CTR_INIT;
      for (int i = 0; i < RAS_DEPTH; i++)
        ras[i] <= '0;
      ptr   <= '0;
      count <= '0;
    end else begin
      if (bp.update_en) begin
        if (bp.update_taken) begin
          if (u_ctr != CTR_MAX)
            bht[u_idx] <= u_ctr + 1'b1;
        end else begin
          if (u_ctr != '0)
            bht[u_idx] <= u_ctr - 1'b1;
        end
      end
      if (do_pop && ras_nz && do_push) begin
        ras[top_idx] <= pc4;
      end else if (do_push) begin
        ras[ptr] <= pc4;
        ptr      <= ptr + 1'b1;
        if (count != FULL)
          count <= count + 1'b1;
      end else if (do_pop && ras_nz) begin
        ptr   <= ptr - 1'b1;
        count <= count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Directed bench for dynamic_branch_predictor.
// Each task drives one scenario and checks inline.
module tb_dynamic_branch_predictor;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  dynamic_branch_predictor_if #(.DATA_WIDTH(32)) bp ();

  dynamic_branch_predictor #(
    .DATA_WIDTH(32),
    .BHT_INDEX_BITS(6),
    .CTR_BITS(2),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp(bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] br(input int imm);
    logic [12:0] b;
    b = imm[12:0];
    return {b[12], b[10:5], 5'd0, 5'd0, 3'b000,
            b[4:1], b[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] jal(
    input logic [4:0] rd, input int imm);
    logic [20:0] j;
    j = imm[20:0];
    return {j[20], j[10:1], j[11], j[19:12],
            rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] jalr(
    input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc,
                       input logic [31:0] ins,
                       input logic fe);
    bp.PC_f     = pc;
    bp.RD       = ins;
    bp.fetch_en = fe;
    #1;
  endtask

  task automatic train(input logic [31:0] pc,
                       input logic tk);
    bp.fetch_en     = 1'b0;
    bp.update_en    = 1'b1;
    bp.update_pc    = pc;
    bp.update_taken = tk;
    tick();
    bp.update_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bp.fetch_en = 1'b0;
    bp.update_en = 1'b0;
    bp.update_pc = '0;
    bp.update_taken = 1'b0;
    bp.RD = 32'h0000_0013;
    bp.PC_f = '0;
    tick();
    tick();
    rst = 1'b0;
    drive(32'h100, br(-8), 1'b0);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b0, 32'h0F8}) begin
      errors++;
      $display("FAIL rst_br got %b/%h exp 0/0f8",
               bp.predict_taken, bp.branch_target);
    end
    drive(32'h400, jalr(5'd0, 5'd1), 1'b0);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b0, 32'h404}) begin
      errors++;
      $display("FAIL rst_jalr got %b/%h exp 0/404",
               bp.predict_taken, bp.branch_target);
    end
    drive(32'h300, 32'h0000_0013, 1'b0);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b0, 32'h304}) begin
      errors++;
      $display("FAIL other_op got %b/%h exp 0/304",
               bp.predict_taken, bp.branch_target);
    end
    drive(32'hFFFF_FFFC, br(8), 1'b0);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b0, 32'h4}) begin
      errors++;
      $display("FAIL br_wrap got %b/%h exp 0/4",
               bp.predict_taken, bp.branch_target);
    end
    drive(32'h0, jal(5'd0, -4), 1'b0);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++;
      $display("FAIL jal_wrap got %b/%h exp 1/fffffffc",
               bp.predict_taken, bp.branch_target);
    end
  endtask

  task automatic test_bht_train();
    train(32'h100, 1'b1);
    train(32'h100, 1'b1);
    drive(32'h100, br(-8), 1'b0);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b1, 32'h0F8}) begin
      errors++;
      $display("FAIL bht_taken got %b/%h exp 1/0f8",
               bp.predict_taken, bp.branch_target);
    end
    drive(32'h1100, br(16), 1'b0);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b1, 32'h1110}) begin
      errors++;
      $display("FAIL bht_alias got %b/%h exp 1/1110",
               bp.predict_taken, bp.branch_target);
    end
    drive(32'h104, br(-8), 1'b0);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b0, 32'h0FC}) begin
      errors++;
      $display("FAIL bht_other got %b/%h exp 0/0fc",
               bp.predict_taken, bp.branch_target);
    end
    for (int i = 0; i < 3; i++) train(32'h100, 1'b1);
    drive(32'h100, br(-8), 1'b0);
    checks++;
    if (bp.predict_taken !== 1'b1) begin
      errors++;
      $display("FAIL bht_sat got %b exp 1",
               bp.predict_taken);
    end
    train(32'h100, 1'b0);
    drive(32'h100, br(-8), 1'b0);
    checks++;
    if (bp.predict_taken !== 1'b1) begin
      errors++;
      $display("FAIL bht_nt1 got %b exp 1",
               bp.predict_taken);
    end
    train(32'h100, 1'b0);
    drive(32'h100, br(-8), 1'b0);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b0, 32'h0F8}) begin
      errors++;
      $display("FAIL bht_nt2 got %b/%h exp 0/0f8",
               bp.predict_taken, bp.branch_target);
    end
  endtask

  task automatic test_call_ret();
    drive(32'h200, jal(5'd1, 32'h200), 1'b1);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b1, 32'h400}) begin
      errors++;
      $display("FAIL call_jal got %b/%h exp 1/400",
               bp.predict_taken, bp.branch_target);
    end
    tick();
    drive(32'h400, jalr(5'd0, 5'd1), 1'b1);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b1, 32'h204}) begin
      errors++;
      $display("FAIL ret_jalr got %b/%h exp 1/204",
               bp.predict_taken, bp.branch_target);
    end
    tick();
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b0, 32'h404}) begin
      errors++;
      $display("FAIL ret_empty got %b/%h exp 0/404",
               bp.predict_taken, bp.branch_target);
    end
    tick();
    bp.fetch_en = 1'b0;
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp;
    for (int k = 0; k < 5; k++) begin
      drive(32'h1000 + 32'(16 * k),
            jal(5'd1, 32'h100), 1'b1);
      exp = 32'h1100 + 32'(16 * k);
      checks++;
      if ({bp.predict_taken, bp.branch_target}
          !== {1'b1, exp}) begin
        errors++;
        $display("FAIL push_%0d got %b/%h exp 1/%h", k,
                 bp.predict_taken, bp.branch_target, exp);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(32'h3000, jalr(5'd0, 5'd1), 1'b1);
      exp = 32'h1044 - 32'(16 * k);
      checks++;
      if ({bp.predict_taken, bp.branch_target}
          !== {1'b1, exp}) begin
        errors++;
        $display("FAIL pop_%0d got %b/%h exp 1/%h", k,
                 bp.predict_taken, bp.branch_target, exp);
      end
      tick();
    end
    drive(32'h3000, jalr(5'd0, 5'd1), 1'b1);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b0, 32'h3004}) begin
      errors++;
      $display("FAIL pop_4 got %b/%h exp 0/3004",
               bp.predict_taken, bp.branch_target);
    end
    tick();
  endtask

  task automatic test_coroutine();
    drive(32'h500, jal(5'd1, 32'h40), 1'b1);
    tick();
    drive(32'h600, jalr(5'd1, 5'd5), 1'b1);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b1, 32'h504}) begin
      errors++;
      $display("FAIL swap_pred got %b/%h exp 1/504",
               bp.predict_taken, bp.branch_target);
    end
    tick();
    drive(32'h3000, jalr(5'd0, 5'd1), 1'b1);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b1, 32'h604}) begin
      errors++;
      $display("FAIL swap_top got %b/%h exp 1/604",
               bp.predict_taken, bp.branch_target);
    end
    tick();
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b0, 32'h3004}) begin
      errors++;
      $display("FAIL swap_cnt got %b/%h exp 0/3004",
               bp.predict_taken, bp.branch_target);
    end
    drive(32'h700, jalr(5'd1, 5'd1), 1'b1);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b0, 32'h704}) begin
      errors++;
      $display("FAIL same_link got %b/%h exp 0/704",
               bp.predict_taken, bp.branch_target);
    end
    tick();
    drive(32'h3000, jalr(5'd0, 5'd1), 1'b1);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b1, 32'h704}) begin
      errors++;
      $display("FAIL same_push got %b/%h exp 1/704",
               bp.predict_taken, bp.branch_target);
    end
    tick();
    bp.fetch_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    bp.update_en    = 1'b1;
    bp.update_pc    = 32'h108;
    bp.update_taken = 1'b1;
    drive(32'h108, br(-8), 1'b0);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b0, 32'h100}) begin
      errors++;
      $display("FAIL same_old got %b/%h exp 0/100",
               bp.predict_taken, bp.branch_target);
    end
    tick();
    bp.update_en = 1'b0;
    drive(32'h108, br(-8), 1'b0);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b1, 32'h100}) begin
      errors++;
      $display("FAIL same_new got %b/%h exp 1/100",
               bp.predict_taken, bp.branch_target);
    end
    drive(32'h800, jal(5'd1, 32'h10), 1'b1);
    tick();
    drive(32'h3000, jalr(5'd0, 5'd1), 1'b0);
    tick();
    tick();
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b1, 32'h804}) begin
      errors++;
      $display("FAIL fe0_hold got %b/%h exp 1/804",
               bp.predict_taken, bp.branch_target);
    end
    bp.fetch_en = 1'b1;
    tick();
    bp.fetch_en = 1'b0;
    #1;
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b0, 32'h3004}) begin
      errors++;
      $display("FAIL fe1_pop got %b/%h exp 0/3004",
               bp.predict_taken, bp.branch_target);
    end
  endtask

  task automatic test_mid_reset();
    train(32'h10C, 1'b1);
    train(32'h10C, 1'b1);
    drive(32'h900, jal(5'd1, 32'h10), 1'b1);
    tick();
    drive(32'h10C, br(-8), 1'b0);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b1, 32'h104}) begin
      errors++;
      $display("FAIL pre_rst got %b/%h exp 1/104",
               bp.predict_taken, bp.branch_target);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b0, 32'h104}) begin
      errors++;
      $display("FAIL async_br got %b/%h exp 0/104",
               bp.predict_taken, bp.branch_target);
    end
    drive(32'h3000, jalr(5'd0, 5'd1), 1'b0);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b0, 32'h3004}) begin
      errors++;
      $display("FAIL async_jalr got %b/%h exp 0/3004",
               bp.predict_taken, bp.branch_target);
    end
    tick();
    rst = 1'b0;
    drive(32'h3000, jalr(5'd0, 5'd1), 1'b0);
    checks++;
    if ({bp.predict_taken, bp.branch_target}
        !== {1'b0, 32'h3004}) begin
      errors++;
      $display("FAIL post_rst got %b/%h exp 0/3004",
               bp.predict_taken, bp.branch_target);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_bht_train();
    test_call_ret();
    test_ras_overflow();
    test_coroutine();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
